// File: rtl/cla_pkg.sv
// Carry-lookahead helpers shared by the CLA adder and CLS subtractor datapaths.
// pg4 folds four propagate/generate pairs; pg_merge joins an upper and a lower span.
package cla_pkg;

    localparam int CLA_GROUP = 16;

    // Returns {P, G} for a 4-wide span, bit 3 most significant.
    function automatic logic [1:0] pg4(input logic [3:0] p, input logic [3:0] g);
        logic grp_p;
        logic grp_g;
        grp_p = &p;
        grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        return {grp_p, grp_g};
    endfunction

    function automatic logic [1:0] pg_merge(input logic hi_p, input logic hi_g,
                                            input logic lo_p, input logic lo_g);
        return {hi_p & lo_p, hi_g | (hi_p & lo_g)};
    endfunction

endpackage

// File: rtl/cla_group16.sv
// Combinational 16-bit lookahead slice: two-level pg4 tree gives the slice carry-out
// and group P/G; nibble carries feed the per-bit sums.
module cla_group16
    import cla_pkg::*;
(
    input  logic [CLA_GROUP-1:0] a,
    input  logic [CLA_GROUP-1:0] b,
    input  logic                 ci,
    output logic [CLA_GROUP-1:0] s,
    output logic                 co,
    output logic                 grp_p,
    output logic                 grp_g
);

    localparam int NIB = CLA_GROUP / 4;

    logic [CLA_GROUP-1:0] p;
    logic [CLA_GROUP-1:0] g;
    logic [NIB-1:0]       np;
    logic [NIB-1:0]       ng;
    logic                 c_nib;
    logic                 c_bit;

    assign p = a ^ b;
    assign g = a & b;

    always_comb begin
        np    = '0;
        ng    = '0;
        s     = '0;
        c_nib = ci;
        c_bit = ci;
        for (int n = 0; n < NIB; n++) begin
            {np[n], ng[n]} = pg4(p[4*n +: 4], g[4*n +: 4]);
        end
        {grp_p, grp_g} = pg4(np, ng);
        co = grp_g | (grp_p & ci);
        // Each nibble starts from its lookahead carry; bits inside ripple locally.
        for (int n = 0; n < NIB; n++) begin
            c_bit = c_nib;
            for (int j = 0; j < 4; j++) begin
                s[4*n+j] = p[4*n+j] ^ c_bit;
                c_bit    = g[4*n+j] | (p[4*n+j] & c_bit);
            end
            c_nib = ng[n] | (np[n] & c_nib);
        end
    end

endmodule

// File: rtl/cla_add64_pipe.sv
// Pipelined carry-lookahead adder: one GROUP-bit slice resolved per stage, operands skewed
// forward, elastic valid/ready flow with bubble collapse and per-stage stall enables.
module cla_add64_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int GROUP = CLA_GROUP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             gp,
    output logic             gg
);

    localparam int STAGES = WIDTH / GROUP;

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] en;

    // A stage may load when it is empty or the stage after it is moving.
    always_comb begin
        en             = '0;
        en[STAGES-1]   = out_ready | ~vld[STAGES-1];
        for (int k = STAGES - 2; k >= 0; k--) begin
            en[k] = en[k+1] | ~vld[k];
        end
    end

    assign in_ready = en[0];

    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int LO = k * GROUP;
        localparam int SW = (k + 1) * GROUP;

        logic [GROUP-1:0] a_sl;
        logic [GROUP-1:0] b_sl;
        logic             ci_sl;
        logic             take;
        logic [GROUP-1:0] s_sl;
        logic             co_sl;
        logic             p_sl;
        logic             g_sl;
        logic             gp_n;
        logic             gg_n;
        logic [SW-1:0]    sum_n;

        logic             v_q;
        logic             c_q;
        logic             gp_q;
        logic             gg_q;
        logic [SW-1:0]    sum_q;

        if (k == 0) begin : src
            assign a_sl  = in_a[GROUP-1:0];
            assign b_sl  = in_b[GROUP-1:0];
            assign ci_sl = cin;
            assign take  = in_valid;
            assign gp_n  = p_sl;
            assign gg_n  = g_sl;
            assign sum_n = s_sl;
        end else begin : src
            assign a_sl  = stg[k-1].skew.a_q[GROUP-1:0];
            assign b_sl  = stg[k-1].skew.b_q[GROUP-1:0];
            assign ci_sl = stg[k-1].c_q;
            assign take  = stg[k-1].v_q;
            assign {gp_n, gg_n} = pg_merge(p_sl, g_sl, stg[k-1].gp_q, stg[k-1].gg_q);
            assign sum_n = {s_sl, stg[k-1].sum_q};
        end

        cla_group16 u_grp (
            .a     (a_sl),
            .b     (b_sl),
            .ci    (ci_sl),
            .s     (s_sl),
            .co    (co_sl),
            .grp_p (p_sl),
            .grp_g (g_sl)
        );

        // Result registers change only when a real operation lands, so bubbles keep the last value.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                gp_q  <= 1'b0;
                gg_q  <= 1'b0;
                sum_q <= '0;
            end else if (en[k]) begin
                v_q <= take;
                if (take) begin
                    c_q   <= co_sl;
                    gp_q  <= gp_n;
                    gg_q  <= gg_n;
                    sum_q <= sum_n;
                end
            end
        end

        assign vld[k] = v_q;

        if (k < STAGES - 1) begin : skew
            logic [WIDTH-SW-1:0] a_q;
            logic [WIDTH-SW-1:0] b_q;
            logic [WIDTH-SW-1:0] a_nx;
            logic [WIDTH-SW-1:0] b_nx;

            if (k == 0) begin : nx
                assign a_nx = in_a[WIDTH-1:GROUP];
                assign b_nx = in_b[WIDTH-1:GROUP];
            end else begin : nx
                assign a_nx = stg[k-1].skew.a_q[WIDTH-LO-1:GROUP];
                assign b_nx = stg[k-1].skew.b_q[WIDTH-LO-1:GROUP];
            end

            always_ff @(posedge clk) begin
                if (en[k] && take) begin
                    a_q <= a_nx;
                    b_q <= b_nx;
                end
            end
        end
    end

    assign out_valid = stg[STAGES-1].v_q;
    assign sum       = stg[STAGES-1].sum_q;
    assign cout      = stg[STAGES-1].c_q;
    assign gp        = stg[STAGES-1].gp_q;
    assign gg        = stg[STAGES-1].gg_q;

endmodule
